jtag_debug_mux: RTL

Parametrised multi-target JTAG tunnelling bridge between the FPGA user-JTAG (UJTAG) data-register interface and up to eight on-chip debug TAPs (RISC-V debug modules). Each target has its own user IR code. The host tunnels target TMS/TDI as bit pairs through a user DR scan, and the bridge generates the target TCK at half the TCK rate. A separate control IR gives per-target TRST control. The block sits between the UJTAG macro and the processor debug ports, replacing the single-target bridge.

---
 rtl/jtag_debug_mux_if.sv | 27 ++
 rtl/jtag_debug_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_mux_if.sv
// jtag_debug_mux_if: UJTAG user-DR signals plus the per-target debug TAP pins.
// master = UJTAG/target side that drives the bridge, slave = the bridge itself.
interface jtag_debug_mux_if #(
  parameter int NUM_TGT = 2
);
  logic [7:0]         uireg;
  logic               udrcap;
  logic               udrsh;
  logic               udrupd;
  logic               utdi;
  logic               utdo;
  logic [NUM_TGT-1:0] tgt_tck;
  logic [NUM_TGT-1:0] tgt_tms;
  logic [NUM_TGT-1:0] tgt_tdi;
  logic [NUM_TGT-1:0] tgt_trst;
  logic [NUM_TGT-1:0] tgt_tdo;

  modport master (
    output uireg, udrcap, udrsh, udrupd, utdi, tgt_tdo,
    input  utdo, tgt_tck, tgt_tms, tgt_tdi, tgt_trst
  );

  modport slave (
    input  uireg, udrcap, udrsh, udrupd, utdi, tgt_tdo,
    output utdo, tgt_tck, tgt_tms, tgt_tdi, tgt_trst
  );
endinterface

// File: rtl/jtag_debug_mux.sv
// jtag_debug_mux: tunnels TMS/TDI bit pairs from a UJTAG user DR scan to one of
// NUM_TGT debug TAPs, generating the target TCK at half the scan rate.
// Optional feature macro: JTAG_DEBUG_MUX_CTRL_EN adds the IR_CTRL register that
// drives per-target TRST; without it each TRST is a flop cleared after reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no pair in flight, target clocks low
// ST_TMS   | next shift bit is the TMS half of a pair
// ST_TDI   | next shift bit is TDI; apply TMS/TDI and drop target TCK
// ST_RISE  | raise target TCK, sample TDO; next bit (if any) is a new TMS
// ST_FLUSH | scan ended after a full pair; target TCK high, drop it next
module jtag_debug_mux #(
  parameter int         NUM_TGT      = 2,
  parameter logic [7:0] IR_CODE_BASE = 8'h55,
  parameter logic [7:0] IR_CTRL      = 8'h50
) (
  input logic             tck,
  input logic             trst,
  jtag_debug_mux_if.slave bus
);
  localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_TMS, ST_TDI, ST_RISE, ST_FLUSH} state_t;
  typedef enum logic [1:0] {MODE_IDLE, MODE_CHAN, MODE_CTRL} mode_t;

  state_t             state, state_nxt;
  mode_t              mode;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   hit_sel;
  logic               hit_chan;
  logic               hit_ctrl;
  logic               grab_tms, do_pair, do_rise, do_fall;
  logic               tms_hold;
  logic               tdo_reg;
  logic               ctrl_tdo;
  logic [NUM_TGT-1:0] tck_q, tms_q, tdi_q;

  // Decode the current user IR into a channel hit or a control-register hit.
  always_comb begin
    hit_chan = 1'b0;
    hit_sel  = '0;
    for (int n = 0; n < NUM_TGT; n++) begin
      if (bus.uireg == IR_CODE_BASE + 8'(n)) begin
        hit_chan = 1'b1;
        hit_sel  = SEL_W'(n);
      end
    end
`ifdef JTAG_DEBUG_MUX_CTRL_EN
    hit_ctrl = (bus.uireg == IR_CTRL);
`else
    hit_ctrl = 1'b0;
`endif
  end

  // Latch the mode and selected channel at capture-DR.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      mode <= MODE_IDLE;
      sel  <= '0;
    end else if (bus.udrcap) begin
      mode <= hit_chan ? MODE_CHAN : (hit_ctrl ? MODE_CTRL : MODE_IDLE);
      sel  <= hit_sel;
    end
  end

  // Pair FSM state register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Pair FSM next state and datapath strobes.
  always_comb begin
    state_nxt = state;
    grab_tms  = 1'b0;
    do_pair   = 1'b0;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    if (bus.udrcap) begin
      state_nxt = hit_chan ? ST_TMS : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_TMS: begin
          if (bus.udrsh) begin
            grab_tms  = 1'b1;
            state_nxt = ST_TDI;
          end else if (bus.udrupd) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_TDI: begin
          if (bus.udrsh) begin
            do_pair   = 1'b1;
            state_nxt = ST_RISE;
          end else begin
            // lone TMS bit: only finish the previous pair's low phase
            do_fall   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_RISE: begin
          do_rise   = 1'b1;
          grab_tms  = bus.udrsh;
          state_nxt = bus.udrsh ? ST_TDI : ST_FLUSH;
        end
        ST_FLUSH: begin
          do_fall   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Target pin registers, TMS holding flop and TDO sample.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      tck_q    <= '0;
      tms_q    <= '1;
      tdi_q    <= '0;
      tms_hold <= 1'b0;
      tdo_reg  <= 1'b0;
    end else begin
      if (grab_tms) tms_hold <= bus.utdi;
      if (bus.udrcap) begin
        tck_q   <= '0;
        tdo_reg <= 1'b0;
      end else if (do_pair) begin
        tms_q[sel] <= tms_hold;
        tdi_q[sel] <= bus.utdi;
        tck_q[sel] <= 1'b0;
      end else if (do_rise) begin
        tck_q[sel] <= 1'b1;
        tdo_reg    <= bus.tgt_tdo[sel];
      end else if (do_fall) begin
        tck_q[sel] <= 1'b0;
      end
    end
  end

`ifdef JTAG_DEBUG_MUX_CTRL_EN
  logic [7:0]         ctrl_sr;
  logic [7:0]         ctrl_cap;
  logic [NUM_TGT-1:0] trst_mask;

  // Capture value: current mask zero-extended to the 8-bit register.
  always_comb begin
    ctrl_cap                = '0;
    ctrl_cap[NUM_TGT-1:0]   = trst_mask;
  end

  // Control register: capture, LSB-first shift, update into the TRST mask.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ctrl_sr   <= '0;
      trst_mask <= '1;
    end else begin
      if (bus.udrcap && hit_ctrl)
        ctrl_sr <= ctrl_cap;
      else if (mode == MODE_CTRL && bus.udrsh)
        ctrl_sr <= {bus.utdi, ctrl_sr[7:1]};
      if (mode == MODE_CTRL && bus.udrupd && !bus.udrcap)
        trst_mask <= ctrl_sr[NUM_TGT-1:0];
    end
  end

  assign ctrl_tdo     = ctrl_sr[0];
  assign bus.tgt_trst = trst_mask;
`else
  logic [NUM_TGT-1:0] trst_q;

  // Hold every target in reset until the first TCK after TRST releases.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) trst_q <= '1;
    else      trst_q <= '0;
  end

  assign ctrl_tdo     = 1'b0;
  assign bus.tgt_trst = trst_q;
`endif

  assign bus.utdo    = (mode == MODE_CHAN) ? tdo_reg :
                       (mode == MODE_CTRL) ? ctrl_tdo : 1'b0;
  assign bus.tgt_tck = tck_q;
  assign bus.tgt_tms = tms_q;
  assign bus.tgt_tdi = tdi_q;
endmodule
